ft245_dev_emu: RTL

Synthesizable emulator of the FT245R device side of the parallel FIFO bus. It is the responder that FTUART_TXRX talks to. It drives RXF/TXE, answers the active-low RD/WR strobes and owns the 8-bit data bus. Behind the bus it holds two FIFOs:
- an RX FIFO, filled from a USB-side injection port;
- a TX FIFO, drained through a USB-side drain port.

It is used on-chip for loopback builds and in benches as the reference bus partner.

---
 rtl/ft245_dev_emu.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ft245_dev_emu.sv
// Device-side emulator of an FT245R parallel FIFO bus: synchronizes the host
// RD/WR strobes, answers them from an RX FIFO / into a TX FIFO, and exposes USB-side ports.
module ft245_dev_emu #(
  parameter int DEPTH = 16,
  parameter int RECOV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_oe,
  output logic       rxf,
  output logic       txe,
  input  logic [7:0] usb_rx_data,
  input  logic       usb_rx_valid,
  output logic       usb_rx_ready,
  output logic [7:0] usb_tx_data,
  output logic       usb_tx_valid,
  input  logic       usb_tx_ready,
  output logic [2:0] err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RECOV + 1);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_DRIVE = 2'd1;
  localparam logic [1:0] R_RECOV = 2'd2;
  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_HOLD  = 2'd1;
  localparam logic [1:0] W_RECOV = 2'd2;

  logic       rd_s1, rd_s2, rd_s3, wr_s1, wr_s2, wr_s3;
  logic [7:0] data_s1, data_s2;
  logic [1:0] settle;
  logic       rd_armed, wr_armed, usb_en;
  logic [1:0] rstate, wstate;
  logic [CW-1:0] rcnt, wcnt;

  logic [7:0]  rx_mem [DEPTH];
  logic [7:0]  tx_mem [DEPTH];
  logic [AW:0] rx_wptr, rx_rptr, tx_wptr, tx_rptr;
  logic        rx_full, rx_empty, tx_full, tx_empty;
  logic        rx_push, rx_pop, tx_push, tx_pop;
  logic        rd_fall, rd_rise, wr_fall, wr_rise;
  logic        rd_go, wr_go, rd_coll, wr_coll;

  // A strobe only counts as an edge once it has been seen high after reset,
  // so a strobe held low across reset release is ignored until it cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_s1    <= 1'b1;
      rd_s2    <= 1'b1;
      rd_s3    <= 1'b1;
      wr_s1    <= 1'b1;
      wr_s2    <= 1'b1;
      wr_s3    <= 1'b1;
      data_s1  <= 8'h00;
      data_s2  <= 8'h00;
      settle   <= 2'd0;
      rd_armed <= 1'b0;
      wr_armed <= 1'b0;
      usb_en   <= 1'b0;
    end else begin
      rd_s1   <= rd;
      rd_s2   <= rd_s1;
      rd_s3   <= rd_s2;
      wr_s1   <= wr;
      wr_s2   <= wr_s1;
      wr_s3   <= wr_s2;
      data_s1 <= data_i;
      data_s2 <= data_s1;
      usb_en  <= 1'b1;
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && rd_s2) rd_armed <= 1'b1;
      if (settle == 2'd3 && wr_s2) wr_armed <= 1'b1;
    end
  end

  assign rd_fall = rd_armed & rd_s3 & ~rd_s2;
  assign rd_rise = rd_armed & ~rd_s3 & rd_s2;
  assign wr_fall = wr_armed & wr_s3 & ~wr_s2;
  assign wr_rise = wr_armed & ~wr_s3 & wr_s2;

  assign rd_go   = rd_fall & (rstate == R_IDLE) & (wstate == W_IDLE);
  assign rd_coll = rd_fall & (wstate != W_IDLE);
  assign wr_go   = wr_fall & (wstate == W_IDLE) & (rstate == R_IDLE);
  assign wr_coll = wr_fall & (rstate != R_IDLE);

  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);

  assign usb_rx_ready = usb_en & ~rx_full;
  assign rx_push      = usb_rx_valid & usb_rx_ready;
  assign rx_pop       = (rstate == R_DRIVE) & rd_rise & ~rx_empty;
  assign tx_push      = wr_go & ~tx_full;
  assign usb_tx_valid = ~tx_empty;
  assign usb_tx_data  = tx_mem[tx_rptr[AW-1:0]];
  assign tx_pop       = usb_tx_valid & usb_tx_ready;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= usb_rx_data;
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= data_s2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
      if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
      if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
      if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
    end
  end

  // Recovery leaves the state on the edge where the counter reaches zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate  <= R_IDLE;
      rcnt    <= '0;
      data_o  <= 8'h00;
      data_oe <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: if (rd_go) begin
          data_o  <= rx_empty ? 8'h00 : rx_mem[rx_rptr[AW-1:0]];
          data_oe <= 1'b1;
          rstate  <= R_DRIVE;
        end
        R_DRIVE: if (rd_rise) begin
          data_oe <= 1'b0;
          rcnt    <= CW'(RECOV);
          rstate  <= R_RECOV;
        end
        default: begin
          rcnt <= rcnt - CW'(1);
          if (rcnt <= CW'(1)) rstate <= R_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate <= W_IDLE;
      wcnt   <= '0;
    end else begin
      case (wstate)
        W_IDLE: if (wr_go) wstate <= W_HOLD;
        W_HOLD: if (wr_rise) begin
          wcnt   <= CW'(RECOV);
          wstate <= W_RECOV;
        end
        default: begin
          wcnt <= wcnt - CW'(1);
          if (wcnt <= CW'(1)) wstate <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxf <= 1'b1;
      txe <= 1'b1;
      err <= 3'b000;
    end else begin
      rxf    <= ~((rstate == R_IDLE) & ~rx_empty);
      txe    <= ~((wstate == W_IDLE) & ~tx_full);
      err[0] <= err[0] | (wr_go & tx_full);
      err[1] <= err[1] | (rd_go & rx_empty);
      err[2] <= err[2] | rd_coll | wr_coll;
    end
  end

endmodule
